// File: rtl/glogic_acc.sv
// rtl/glogic_acc.sv - registered bitwise gate with per-beat or burst-folding mode
//
// Purpose: applies one of eight bitwise functions (AND, OR, XOR, NAND, NOR,
// XNOR, PASS_A, NOT_A) to two WIDTH-bit operands. In single mode each accepted
// beat produces one result; in accumulate mode the function is folded over a
// burst, using b only on the first beat and the accumulator afterwards.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   a, b, op            operands and function select
//   acc, last           burst start (sampled in IDLE) and final-beat marker
//   in_valid/in_ready   input handshake
//   y, cnt, sat         result, beats folded, beat counter saturated
//   out_valid/out_ready output handshake
//   par                 ^y, present only when GLOGIC_ACC_PARITY_EN is defined
module glogic_acc #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] cnt,
  output logic             sat,
  output logic             out_valid,
`ifdef GLOGIC_ACC_PARITY_EN
  output logic             par,
`endif
  input  logic             out_ready
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]       state;
  logic [WIDTH-1:0] accum;
  logic [2:0]       op_l;
  logic [CNT_W-1:0] beats;
  logic             sticky;

  logic             accept;
  logic             load;
  logic [WIDTH-1:0] res_idle;
  logic [WIDTH-1:0] res_acc;
  logic [CNT_W-1:0] beats_inc;
  logic [WIDTH-1:0] load_y;
  logic [CNT_W-1:0] load_cnt;
  logic             load_sat;

  function automatic logic [WIDTH-1:0] gate_f(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] z,
                                              input logic [2:0]       sel);
    case (sel)
      3'd0:    gate_f = x & z;
      3'd1:    gate_f = x | z;
      3'd2:    gate_f = x ^ z;
      3'd3:    gate_f = ~(x & z);
      3'd4:    gate_f = ~(x | z);
      3'd5:    gate_f = ~(x ^ z);
      3'd6:    gate_f = x;
      default: gate_f = ~x;
    endcase
  endfunction

  // Ready depends only on the output register so a stalled consumer never
  // lets a new result overwrite one it has not taken yet.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    res_idle  = gate_f(a, b, op);
    res_acc   = gate_f(accum, a, op_l);
    beats_inc = (beats == CNT_MAX) ? CNT_MAX : beats + CNT_ONE;
    if (state == S_IDLE) begin
      load     = accept && (!acc || last);
      load_y   = res_idle;
      load_cnt = CNT_ONE;
      load_sat = 1'b0;
    end else begin
      load     = accept && last;
      load_y   = res_acc;
      load_cnt = beats_inc;
      load_sat = sticky || (beats_inc == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      accum     <= '0;
      op_l      <= '0;
      beats     <= '0;
      sticky    <= 1'b0;
      y         <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
`ifdef GLOGIC_ACC_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        if (state == S_IDLE) begin
          if (acc) begin
            accum <= res_idle;
            op_l  <= op;
            if (!last) begin
              state  <= S_ACC;
              beats  <= CNT_ONE;
              sticky <= (CNT_ONE == CNT_MAX);
            end
          end
        end else begin
          accum <= res_acc;
          if (last) begin
            state  <= S_IDLE;
            beats  <= '0;
            sticky <= 1'b0;
          end else begin
            beats  <= beats_inc;
            sticky <= sticky || (beats_inc == CNT_MAX);
          end
        end
      end

      if (load) begin
        y         <= load_y;
        cnt       <= load_cnt;
        sat       <= load_sat;
        out_valid <= 1'b1;
`ifdef GLOGIC_ACC_PARITY_EN
        par       <= ^load_y;
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_glogic_acc.sv
// tb/tb_glogic_acc.sv - directed self-checking bench for glogic_acc
module tb_glogic_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic [2:0]  op;
  logic        acc, last, in_valid, out_ready;

  logic        u0_in_ready, u0_sat, u0_out_valid;
  logic [15:0] u0_y;
  logic [7:0]  u0_cnt;
  logic        u1_in_ready, u1_sat, u1_out_valid;
  logic [15:0] u1_y;
  logic [1:0]  u1_cnt;
`ifdef GLOGIC_ACC_PARITY_EN
  logic        u0_par, u1_par;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  glogic_acc #(.WIDTH(16), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .acc(acc), .last(last),
    .in_valid(in_valid), .in_ready(u0_in_ready), .y(u0_y), .cnt(u0_cnt),
    .sat(u0_sat), .out_valid(u0_out_valid),
`ifdef GLOGIC_ACC_PARITY_EN
    .par(u0_par),
`endif
    .out_ready(out_ready)
  );

  glogic_acc #(.WIDTH(16), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .acc(acc), .last(last),
    .in_valid(in_valid), .in_ready(u1_in_ready), .y(u1_y), .cnt(u1_cnt),
    .sat(u1_sat), .out_valid(u1_out_valid),
`ifdef GLOGIC_ACC_PARITY_EN
    .par(u1_par),
`endif
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] ta, input logic [15:0] tb,
                      input logic [2:0] top, input logic tacc, input logic tlast);
    a = ta; b = tb; op = top; acc = tacc; last = tlast; in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; op = '0; acc = 1'b0; last = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    #12;
    chk("reset_y", 32'(u0_y), 32'h0);
    chk("reset_cnt", 32'(u0_cnt), 32'h0);
    chk("reset_sat", 32'(u0_sat), 32'h0);
    chk("reset_out_valid", 32'(u0_out_valid), 32'h0);
    chk("reset_in_ready", 32'(u0_in_ready), 32'h1);
    rst = 1'b0;

    // single beats, back to back
    beat(16'h00F0, 16'h0F00, 3'd1, 1'b0, 1'b0);
    tick();
    chk("or_y", 32'(u0_y), 32'h0FF0);
    chk("or_cnt", 32'(u0_cnt), 32'h1);
    chk("or_sat", 32'(u0_sat), 32'h0);
    chk("or_valid", 32'(u0_out_valid), 32'h1);
    op = 3'd0; tick();
    chk("and_y", 32'(u0_y), 32'h0000);
    op = 3'd2; tick();
    chk("xor_y", 32'(u0_y), 32'h0FF0);
    op = 3'd3; tick();
    chk("nand_y", 32'(u0_y), 32'hFFFF);
`ifdef GLOGIC_ACC_PARITY_EN
    chk("nand_par", 32'(u0_par), 32'h0);
`endif

    // backpressure: held result, pending beat stalls for 5 cycles
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    beat(16'h00FF, 16'h0000, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_in_ready", 32'(u0_in_ready), 32'h0);
      chk("stall_y", 32'(u0_y), 32'hFFFF);
      chk("stall_valid", 32'(u0_out_valid), 32'h1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(u0_in_ready), 32'h1);
    tick();
    chk("release_y", 32'(u0_y), 32'hFF00);
    chk("release_valid", 32'(u0_out_valid), 32'h1);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(u0_out_valid), 32'h0);

    // XOR burst; mid-burst op and b ignored
    beat(16'h000F, 16'h00F0, 3'd2, 1'b1, 1'b0);
    tick();
    chk("burst_no_out", 32'(u0_out_valid), 32'h0);
    beat(16'h0F0F, 16'h1234, 3'd0, 1'b0, 1'b0);
    tick();
    beat(16'hFFFF, 16'h5555, 3'd0, 1'b0, 1'b1);
    tick();
    chk("burst_y", 32'(u0_y), 32'hF00F);
    chk("burst_cnt", 32'(u0_cnt), 32'h3);
    chk("burst_sat", 32'(u0_sat), 32'h0);
    chk("burst_valid", 32'(u0_out_valid), 32'h1);
    in_valid = 1'b0; last = 1'b0;
    tick();

    // burst aborted by reset, then single OR
    beat(16'h00F0, 16'h0F00, 3'd1, 1'b1, 1'b0);
    tick();
    beat(16'h1111, 16'h0000, 3'd1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    beat(16'h0001, 16'h0002, 3'd1, 1'b0, 1'b0);
    tick();
    chk("post_rst_y", 32'(u0_y), 32'h0003);
    chk("post_rst_cnt", 32'(u0_cnt), 32'h1);
    in_valid = 1'b0;
    tick();

    // 1-beat burst (acc=1, last=1) on XNOR
    beat(16'h00FF, 16'h0F0F, 3'd5, 1'b1, 1'b1);
    tick();
    chk("one_beat_y", 32'(u0_y), 32'hF00F);
    chk("one_beat_cnt", 32'(u0_cnt), 32'h1);
    in_valid = 1'b0; last = 1'b0; acc = 1'b0;
    tick();

    // 5-beat OR burst: u1 (CNT_W=2) saturates, u0 does not
    beat(16'h0001, 16'h0000, 3'd1, 1'b1, 1'b0); tick();
    beat(16'h0002, 16'h0000, 3'd1, 1'b0, 1'b0); tick();
    beat(16'h0004, 16'h0000, 3'd1, 1'b0, 1'b0); tick();
    beat(16'h0008, 16'h0000, 3'd1, 1'b0, 1'b0); tick();
    beat(16'h0010, 16'h0000, 3'd1, 1'b0, 1'b1); tick();
    chk("sat_u1_y", 32'(u1_y), 32'h001F);
    chk("sat_u1_cnt", 32'(u1_cnt), 32'h3);
    chk("sat_u1_sat", 32'(u1_sat), 32'h1);
    chk("sat_u0_cnt", 32'(u0_cnt), 32'h5);
    chk("sat_u0_sat", 32'(u0_sat), 32'h0);
    beat(16'h0001, 16'h0000, 3'd1, 1'b0, 1'b0); tick();
    chk("after_sat_u1_sat", 32'(u1_sat), 32'h0);
    chk("after_sat_u1_cnt", 32'(u1_cnt), 32'h1);

    // asynchronous reset with a held result and out_ready low
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("pre_async_valid", 32'(u0_out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_y", 32'(u0_y), 32'h0);
    chk("async_cnt", 32'(u0_cnt), 32'h0);
    chk("async_sat", 32'(u0_sat), 32'h0);
    chk("async_valid", 32'(u0_out_valid), 32'h0);
    chk("async_in_ready", 32'(u0_in_ready), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
